// File: rtl/food_pos_gen.sv
`default_nettype none
// =============================================================================
// food_pos_gen : LFSR-driven food coordinate generator feeding box_create.
//                Optional snake-occupancy check enabled by FOOD_OCC_CHECK_EN.
// Revision     : 1.0
// =============================================================================
module food_pos_gen #(
  parameter int          X_MAX     = 119,
  parameter int          Y_MAX     = 31,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eat,
  output logic       occ_query_valid,
  output logic [6:0] occ_query_x,
  output logic [4:0] occ_query_y,
  input  logic       occ_resp_valid,
  input  logic       occ_hit,
  output logic [6:0] rand_num_x,
  output logic [4:0] rand_num_y,
  output logic       rand_drive,
  output logic       busy,
  output logic       forced
);

  localparam logic [15:0] C_SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] C_POLY = 16'hB400;
  localparam logic [7:0]  C_XMAX = {1'b0, 7'(X_MAX)};
  localparam logic [5:0]  C_YMAX = {1'b0, 5'(Y_MAX)};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAW  = 3'd1,
`ifdef FOOD_OCC_CHECK_EN
    S_QUERY = 3'd3,
    S_WAIT  = 3'd4,
`endif
    S_EMIT  = 3'd2
  } state_t;

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        pending_q;
  logic [6:0]  rand_x_q;
  logic [4:0]  rand_y_q;
  logic        rand_drive_q;
  logic        busy_q;

  logic [6:0]  w_cx;
  logic [4:0]  w_cy;
  logic [7:0]  w_dx;
  logic [5:0]  w_dy;
  logic        w_in_range;

  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ C_POLY) : (lfsr_q >> 1);
  assign w_cx   = lfsr_q[6:0];
  assign w_cy   = lfsr_q[12:8];

  // A borrow out of (MAX - candidate) means the candidate lies beyond the field.
  assign w_dx       = C_XMAX - {1'b0, w_cx};
  assign w_dy       = C_YMAX - {1'b0, w_cy};
  assign w_in_range = ~w_dx[7] & ~w_dy[5];

  assign rand_num_x = rand_x_q;
  assign rand_num_y = rand_y_q;
  assign rand_drive = rand_drive_q;
  assign busy       = busy_q;

`ifdef FOOD_OCC_CHECK_EN
  localparam logic [3:0] C_TRIES = 4'(MAX_TRIES);

  logic [3:0] tries_q;
  logic       forced_q;
  logic       query_valid_q;
  logic [6:0] query_x_q;
  logic [4:0] query_y_q;

  assign occ_query_valid = query_valid_q;
  assign occ_query_x     = query_x_q;
  assign occ_query_y     = query_y_q;
  assign forced          = forced_q;
`else
  logic w_unused_occ;
  assign w_unused_occ    = occ_resp_valid | occ_hit;
  assign occ_query_valid = 1'b0;
  assign occ_query_x     = 7'd0;
  assign occ_query_y     = 5'd0;
  assign forced          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= C_SEED;
      pending_q    <= 1'b0;
      rand_x_q     <= 7'd32;
      rand_y_q     <= 5'd8;
      rand_drive_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FOOD_OCC_CHECK_EN
      tries_q       <= 4'd0;
      forced_q      <= 1'b0;
      query_valid_q <= 1'b0;
      query_x_q     <= 7'd0;
      query_y_q     <= 5'd0;
`endif
    end else begin
      lfsr_q       <= lfsr_d;
      rand_drive_q <= 1'b0;
`ifdef FOOD_OCC_CHECK_EN
      forced_q      <= 1'b0;
      query_valid_q <= 1'b0;
`endif
      if (eat && (state_q != S_IDLE)) pending_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (eat) begin
            state_q <= S_DRAW;
            busy_q  <= 1'b1;
`ifdef FOOD_OCC_CHECK_EN
            tries_q <= 4'd0;
`endif
          end
        end
        S_DRAW: begin
          if (w_in_range) begin
`ifdef FOOD_OCC_CHECK_EN
            if (tries_q < C_TRIES) begin
              query_x_q     <= w_cx;
              query_y_q     <= w_cy;
              query_valid_q <= 1'b1;
              state_q       <= S_QUERY;
            end else begin
              rand_x_q     <= w_cx;
              rand_y_q     <= w_cy;
              rand_drive_q <= 1'b1;
              forced_q     <= (tries_q == C_TRIES);
              state_q      <= S_EMIT;
            end
`else
            rand_x_q     <= w_cx;
            rand_y_q     <= w_cy;
            rand_drive_q <= 1'b1;
            state_q      <= S_EMIT;
`endif
          end
        end
`ifdef FOOD_OCC_CHECK_EN
        S_QUERY: state_q <= S_WAIT;
        S_WAIT: begin
          if (occ_resp_valid) begin
            if (occ_hit) begin
              if (tries_q < C_TRIES) tries_q <= tries_q + 4'd1;
              state_q <= S_DRAW;
            end else begin
              rand_x_q     <= query_x_q;
              rand_y_q     <= query_y_q;
              rand_drive_q <= 1'b1;
              state_q      <= S_EMIT;
            end
          end
        end
`endif
        S_EMIT: begin
          // An eat landing in this very cycle counts as pending too.
          if (pending_q || eat) begin
            state_q   <= S_DRAW;
            pending_q <= 1'b0;
`ifdef FOOD_OCC_CHECK_EN
            tries_q   <= 4'd0;
`endif
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_food_pos_gen.sv
`default_nettype none
// =============================================================================
// tb_food_pos_gen : randomized self-checking bench for food_pos_gen.
// Revision        : 1.0
// =============================================================================
module tb_food_pos_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic eat  = 1'b0;
  logic resp = 1'b0;
  logic hit  = 1'b0;
  int   sel  = 0;

  logic       a_qv, a_rd, a_busy, a_forced;
  logic [6:0] a_qx, a_rx;
  logic [4:0] a_qy, a_ry;
  logic       b_qv, b_rd, b_busy, b_forced;
  logic [6:0] b_qx, b_rx;
  logic [4:0] b_qy, b_ry;
  logic       c_qv, c_rd, c_busy, c_forced;
  logic [6:0] c_qx, c_rx;
  logic [4:0] c_qy, c_ry;

  food_pos_gen dut_a (
    .clk(clk), .rst(rst), .eat(eat && (sel == 0)),
    .occ_query_valid(a_qv), .occ_query_x(a_qx), .occ_query_y(a_qy),
    .occ_resp_valid(resp && (sel == 0)), .occ_hit(hit),
    .rand_num_x(a_rx), .rand_num_y(a_ry), .rand_drive(a_rd),
    .busy(a_busy), .forced(a_forced)
  );

  food_pos_gen #(.X_MAX(15), .Y_MAX(3)) dut_b (
    .clk(clk), .rst(rst), .eat(eat && (sel == 1)),
    .occ_query_valid(b_qv), .occ_query_x(b_qx), .occ_query_y(b_qy),
    .occ_resp_valid(resp && (sel == 1)), .occ_hit(hit),
    .rand_num_x(b_rx), .rand_num_y(b_ry), .rand_drive(b_rd),
    .busy(b_busy), .forced(b_forced)
  );

  food_pos_gen #(.MAX_TRIES(2)) dut_c (
    .clk(clk), .rst(rst), .eat(eat && (sel == 2)),
    .occ_query_valid(c_qv), .occ_query_x(c_qx), .occ_query_y(c_qy),
    .occ_resp_valid(resp && (sel == 2)), .occ_hit(hit),
    .rand_num_x(c_rx), .rand_num_y(c_ry), .rand_drive(c_rd),
    .busy(c_busy), .forced(c_forced)
  );

  logic       o_qv, o_rd, o_busy, o_forced;
  logic [6:0] o_qx, o_rx;
  logic [4:0] o_qy, o_ry;

  always_comb begin
    {o_rd, o_busy, o_forced, o_qv, o_rx, o_qx, o_ry, o_qy} =
      {a_rd, a_busy, a_forced, a_qv, a_rx, a_qx, a_ry, a_qy};
    case (sel)
      1: {o_rd, o_busy, o_forced, o_qv, o_rx, o_qx, o_ry, o_qy} =
           {b_rd, b_busy, b_forced, b_qv, b_rx, b_qx, b_ry, b_qy};
      2: {o_rd, o_busy, o_forced, o_qv, o_rx, o_qx, o_ry, o_qy} =
           {c_rd, c_busy, c_forced, c_qv, c_rx, c_qx, c_ry, c_qy};
      default: ;
    endcase
  end

  // Reference: free-running LFSR plus a clock-edge counter.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic bit cand_ok(input logic [15:0] v, input int xm, input int ym);
    int cx;
    int cy;
    cx = int'(v[6:0]);
    cy = int'(v[12:8]);
    return (cx <= xm) && (cy <= ym);
  endfunction

  logic [15:0] m_lfsr;
  int          cyc = 0;
  always @(posedge clk) begin
    m_lfsr <= rst ? 16'hACE1 : lfsr_next(m_lfsr);
    cyc    <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [6:0] x;
    logic [4:0] y;
  } emit_t;

  emit_t emits[$];
  logic  busy_after[$];
  logic  prev_rd = 1'b0;

  always @(negedge clk) begin
    emit_t e;
    if (prev_rd === 1'b1) busy_after.push_back(o_busy);
    if (o_rd === 1'b1) begin
      e.cyc = cyc;
      e.x   = o_rx;
      e.y   = o_ry;
      emits.push_back(e);
    end
    prev_rd <= o_rd;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_sel(input int s);
    sel = s;
    #1;
  endtask

  task automatic predict(input logic [15:0] start, input int xm, input int ym,
                         output int k, output logic [15:0] v);
    v = start;
    k = 0;
    while (!cand_ok(v, xm, ym) && k < 70000) begin
      v = lfsr_next(v);
      k++;
    end
  endtask

  task automatic single_req(input int xm, input int ym, input string tag);
    int          t, k, waitc;
    logic [15:0] v;
    emit_t       e;
    emits.delete();
    eat = 1'b1;
    tick();
    eat = 1'b0;
    t = cyc;
    predict(m_lfsr, xm, ym, k, v);
    waitc = 0;
    while (emits.size() == 0 && waitc < 4000) begin
      tick();
      waitc++;
    end
    check({tag, " emitted"}, emits.size(), 1);
    if (emits.size() != 0) begin
      e = emits.pop_front();
      check({tag, " latency"}, e.cyc - t, k + 1);
      check({tag, " x"}, e.x, v[6:0]);
      check({tag, " y"}, e.y, v[12:8]);
      tick();
      check({tag, " one-cycle strobe"}, o_rd, 0);
      check({tag, " busy falls"}, o_busy, 0);
    end
  endtask

`ifdef FOOD_OCC_CHECK_EN
  task automatic run_occ(input int n_hits, input int dly, input string tag,
                         output int nq, output logic [6:0] lqx, output logic [4:0] lqy,
                         output int fq_cyc, output logic [6:0] fqx, output logic [4:0] fqy);
    int cnt_dn, waitc;
    nq = 0; cnt_dn = 0; waitc = 0; fq_cyc = -1;
    lqx = '0; lqy = '0; fqx = '0; fqy = '0;
    while (o_rd !== 1'b1 && waitc < 2000) begin
      resp = 1'b0;
      hit  = 1'b0;
      if (o_qv === 1'b1) begin
        nq++;
        lqx = o_qx;
        lqy = o_qy;
        cnt_dn = dly;
        if (nq == 1) begin
          fq_cyc = cyc;
          fqx = o_qx;
          fqy = o_qy;
        end
      end else if (cnt_dn > 0) begin
        cnt_dn--;
        if (cnt_dn == 0) begin
          resp = 1'b1;
          hit  = (nq <= n_hits);
        end
      end
      tick();
      waitc++;
    end
    resp = 1'b0;
    hit  = 1'b0;
    check({tag, " rand_drive"}, o_rd, 1);
  endtask
`endif

  initial begin
    int          t, k1, k2, nq, fq_cyc, waitc;
    logic [15:0] v1, v2, m0;
    logic [6:0]  lqx, fqx;
    logic [4:0]  lqy, fqy;

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    for (int s = 0; s < 2; s++) begin
      set_sel(s);
      check("reset rand_num_x", o_rx, 32);
      check("reset rand_num_y", o_ry, 8);
      check("reset rand_drive", o_rd, 0);
      check("reset busy", o_busy, 0);
      check("reset forced", o_forced, 0);
      check("reset occ_query_valid", o_qv, 0);
    end

    // Abort a draw with reset; nothing may be emitted afterwards.
    set_sel(1);
    eat = 1'b1;
    tick();
    eat = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    emits.delete();
    repeat (20) tick();
    check("abort no emit", emits.size(), 0);
    check("abort busy", o_busy, 0);
    check("abort rand_num_x", o_rx, 32);
    check("abort rand_num_y", o_ry, 8);

`ifndef FOOD_OCC_CHECK_EN
    single_req(15, 3, "post-abort");

    for (int i = 0; i < 200; i++) begin
      single_req(15, 3, "range");
      repeat ($urandom_range(0, 3)) tick();
    end

    set_sel(0);
    for (int i = 0; i < 10; i++) begin
      single_req(119, 31, "default");
      repeat ($urandom_range(0, 4)) tick();
    end

    // Three back-to-back eats: one request plus one collapsed pending request.
    emits.delete();
    busy_after.delete();
    eat = 1'b1;
    tick();
    t  = cyc;
    m0 = m_lfsr;
    tick();
    tick();
    eat = 1'b0;
    repeat (100) tick();
    predict(m0, 119, 31, k1, v1);
    predict(lfsr_next(lfsr_next(v1)), 119, 31, k2, v2);
    check("pending emit count", emits.size(), 2);
    if (emits.size() == 2 && busy_after.size() == 2) begin
      check("pending 1st cycle", emits[0].cyc - t, k1 + 1);
      check("pending 1st x", emits[0].x, v1[6:0]);
      check("pending 2nd cycle", emits[1].cyc - t, k1 + k2 + 3);
      check("pending 2nd x", emits[1].x, v2[6:0]);
      check("pending 2nd y", emits[1].y, v2[12:8]);
      check("pending busy held", busy_after[0], 1);
      check("pending busy falls", busy_after[1], 0);
    end
`else
    // Hit, hit, hit, miss with a 3-cycle responder.
    set_sel(0);
    eat = 1'b1;
    tick();
    eat = 1'b0;
    t = cyc;
    predict(m_lfsr, 119, 31, k1, v1);
    run_occ(3, 3, "retry", nq, lqx, lqy, fq_cyc, fqx, fqy);
    check("retry query count", nq, 4);
    check("retry forced", o_forced, 0);
    check("retry x", o_rx, lqx);
    check("retry y", o_ry, lqy);
    check("retry 1st query cycle", fq_cyc - t, k1 + 1);
    check("retry 1st query x", fqx, v1[6:0]);
    check("retry 1st query y", fqy, v1[12:8]);
    tick();
    check("retry one-cycle strobe", o_rd, 0);
    check("retry busy falls", o_busy, 0);

    // Responder always reports a hit; acceptance is forced after two tries.
    set_sel(2);
    eat = 1'b1;
    tick();
    eat = 1'b0;
    run_occ(99, 2, "forced", nq, lqx, lqy, fq_cyc, fqx, fqy);
    check("forced query count", nq, 2);
    check("forced flag", o_forced, 1);
    check("forced x in range", (o_rx <= 7'd119), 1);
    tick();
    check("forced flag clears", o_forced, 0);

    // Reset while waiting for an answer, then deliver that late answer.
    set_sel(0);
    eat = 1'b1;
    tick();
    eat = 1'b0;
    waitc = 0;
    while (o_qv !== 1'b1 && waitc < 500) begin
      tick();
      waitc++;
    end
    check("wait-reset query seen", o_qv, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    emits.delete();
    repeat (2) tick();
    resp = 1'b1;
    hit  = 1'b0;
    tick();
    resp = 1'b0;
    repeat (20) tick();
    check("wait-reset no emit", emits.size(), 0);
    check("wait-reset busy", o_busy, 0);
    check("wait-reset rand_num_x", o_rx, 32);
    check("wait-reset rand_num_y", o_ry, 8);
    eat = 1'b1;
    tick();
    eat = 1'b0;
    run_occ(0, 1, "wait-reset again", nq, lqx, lqy, fq_cyc, fqx, fqy);
    check("wait-reset again queries", nq, 1);
    check("wait-reset again x", o_rx, lqx);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
